// File: rtl/pwm_dac_out_pkg.sv
// Shared definitions for the PWM DAC output stage: default widths,
// the reset duty helper and the default duty word type.
package pwm_dac_out_pkg;

  localparam int DEF_SIZE     = 32'sd16;
  localparam int DEF_PWM_BITS = 32'sd8;

  // Duty word at the default PWM resolution.
  typedef logic [DEF_PWM_BITS-1:0] duty_t;

  // Duty value that gives a 50% waveform, the zero level of offset-binary audio.
  function automatic int midscale(int bits);
    return 32'sd1 << (bits - 32'sd1);
  endfunction

endpackage

// File: rtl/pwm_dac_out_if.sv
// Sample stream into the PWM DAC: unsigned data with a valid/ready handshake.
interface pwm_dac_out_if #(
  parameter int size = 16
);

  logic [size-1:0] in_data;
  logic            in_vld;
  logic            in_rdy;

  modport master (
    output in_data,
    output in_vld,
    input  in_rdy
  );

  modport slave (
    input  in_data,
    input  in_vld,
    output in_rdy
  );

endinterface

// File: rtl/pwm_dac_out_sample_buf.sv
// One-entry sample buffer. It accepts a truncated sample whenever it is
// empty, or on the consume cycle when the stored entry leaves, so the
// upstream can refill it at the same edge that empties it.
module pwm_dac_out_sample_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [W-1:0] in_sample,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         consume,
  output logic [W-1:0] buf_data,
  output logic         buf_full
);

  logic [W-1:0] buf_q;
  logic [W-1:0] buf_d;
  logic         full_q;
  logic         full_d;
  logic         accept_s;

  // Handshake and next buffer contents; a same-cycle accept wins over consume.
  always_comb begin
    in_rdy   = run & (~full_q | consume);
    accept_s = in_vld & in_rdy;
    buf_d    = buf_q;
    full_d   = full_q;
    if (accept_s) begin
      buf_d  = in_sample;
      full_d = 1'b1;
    end else if (consume) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Buffer storage; reset empties the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= {W{1'b0}};
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end

  assign buf_data = buf_q;
  assign buf_full = full_q;

endmodule

// File: rtl/pwm_dac_out.sv
// PWM audio output stage. A free-running period counter drives a registered
// compare against the duty register; the duty register reloads from the
// one-entry sample buffer only at period boundaries, and an empty buffer at
// a boundary raises a one-cycle underrun pulse.
module pwm_dac_out
  import pwm_dac_out_pkg::*;
#(
  parameter int size     = 16,
  parameter int PWM_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_dac_out_if.slave         in_if,
  output logic                 pwm,
  output logic                 frame_tick,
  output logic                 underrun
);

  localparam logic [PWM_BITS-1:0] MIDSCALE = PWM_BITS'(midscale(PWM_BITS));
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};

  logic                run_q;
  logic                run_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic                pwm_q;
  logic                pwm_d;
  logic                tick_q;
  logic                tick_d;
  logic                underrun_q;
  logic                underrun_d;

  logic                wrap_s;
  logic [PWM_BITS-1:0] buf_data_s;
  logic                buf_full_s;

  // The buffer takes only the top PWM_BITS of each sample; lower bits are dropped.
  pwm_dac_out_sample_buf #(
    .W (PWM_BITS)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run_q),
    .in_sample (in_if.in_data[size-1 -: PWM_BITS]),
    .in_vld    (in_if.in_vld),
    .in_rdy    (in_if.in_rdy),
    .consume   (wrap_s),
    .buf_data  (buf_data_s),
    .buf_full  (buf_full_s)
  );

  // Period counter, duty reload at the wrap and next values of the output flops.
  always_comb begin
    run_d      = 1'b1;
    wrap_s     = (cnt_q == CNT_MAX);
    cnt_d      = cnt_q + CNT_ONE;
    duty_d     = duty_q;
    underrun_d = 1'b0;
    if (wrap_s) begin
      if (buf_full_s) begin
        duty_d     = buf_data_s;
        underrun_d = 1'b0;
      end else begin
        duty_d     = duty_q;
        underrun_d = 1'b1;
      end
    end else begin
      duty_d     = duty_q;
      underrun_d = 1'b0;
    end
    tick_d = wrap_s;
    // Compare against next-cycle values so a new duty applies from cnt==0.
    pwm_d  = (cnt_d < duty_d);
  end

  // State and output registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      cnt_q      <= {PWM_BITS{1'b0}};
      duty_q     <= MIDSCALE;
      pwm_q      <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  assign pwm        = pwm_q;
  assign frame_tick = tick_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Directed bench for pwm_dac_out with size=16, PWM_BITS=4 (16-cycle period).
// Each period is captured as a 16-bit pwm pattern starting at frame_tick.
module tb_pwm_dac_out;

  logic clk = 1'b0;
  logic rst_n;
  logic pwm;
  logic frame_tick;
  logic underrun;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_dac_out_if #(.size(16)) bus ();

  pwm_dac_out #(
    .size     (16),
    .PWM_BITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus.slave),
    .pwm        (pwm),
    .frame_tick (frame_tick),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_in_reset(input string tag);
    chk({tag, "_pwm"}, pwm, 1'b0);
    chk({tag, "_rdy"}, bus.in_rdy, 1'b0);
    chk({tag, "_tick"}, frame_tick, 1'b0);
    chk({tag, "_ur"}, underrun, 1'b0);
  endtask

  // Offer one sample and hold it until accepted; reports ready at first offer.
  task automatic send(input logic [15:0] d, output logic first_rdy);
    logic acc;
    acc = 1'b0;
    bus.in_data = d;
    bus.in_vld  = 1'b1;
    first_rdy   = bus.in_rdy;
    for (int i = 0; i < 64; i++) begin
      if (bus.in_rdy) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.in_vld = 1'b0;
    chk("send_accept", acc, 1'b1);
  endtask

  // Wait for the next period start and capture pwm over that whole period.
  task automatic run_period(input string tag, input logic [15:0] exp_pat, input logic exp_ur);
    logic        found;
    logic        ur;
    logic [15:0] pat;
    int          extra;
    found = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_tick"}, found, 1'b1);
    ur     = underrun;
    pat[0] = pwm;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      pat[i] = pwm;
      if (frame_tick || underrun) extra++;
    end
    chk({tag, "_pwm"}, pat, exp_pat);
    chk({tag, "_ur"}, ur, exp_ur);
    chk({tag, "_flags"}, extra, 0);
  endtask

  logic [15:0] ext_data [3] = '{16'h0000, 16'hFFFF, 16'h8000};
  logic [15:0] ext_pat  [3] = '{16'h0000, 16'h7FFF, 16'h00FF};

  initial begin
    logic r;
    int   n;

    // 1: reset state, mid-period reset, idle behaviour
    rst_n       = 1'b0;
    bus.in_data = 16'h0000;
    bus.in_vld  = 1'b0;
    #1;
    chk_in_reset("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("pre_rst_pwm", pwm, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_in_reset("mid_rst");
    repeat (3) @(negedge clk);
    chk_in_reset("mid_rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    n = 1;
    chk("rdy_after_rst", bus.in_rdy, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (frame_tick) break;
      @(negedge clk);
      n++;
    end
    chk("first_tick_delay", n, 16);
    run_period("idle1", 16'h00FF, 1'b1);
    run_period("idle2", 16'h00FF, 1'b1);

    // 2: 0xC000 -> duty 12 from the next period, then held with underrun
    idle(2);
    send(16'hC000, r);
    run_period("c000", 16'h0FFF, 1'b0);
    run_period("c000_hold", 16'h0FFF, 1'b1);

    // 3: extremes and midscale
    for (int k = 0; k < 3; k++) begin
      idle(2);
      send(ext_data[k], r);
      run_period($sformatf("ext%0d", k), ext_pat[k], 1'b0);
    end

    // 4: back-to-back, second sample stalls until the wrap
    idle(2);
    send(16'h4000, r);
    send(16'hA000, r);
    chk("b2b_stall", r, 1'b0);
    run_period("b2b_4", 16'h000F, 1'b0);
    run_period("b2b_10", 16'h03FF, 1'b0);

    // 5: full buffer refilled on the wrap cycle itself
    idle(2);
    send(16'h2000, r);
    repeat (13) @(negedge clk);
    chk("full_rdy", bus.in_rdy, 1'b0);
    @(negedge clk);
    bus.in_data = 16'hE000;
    bus.in_vld  = 1'b1;
    chk("wrap_rdy", bus.in_rdy, 1'b1);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    run_period("wr_2", 16'h0003, 1'b0);
    run_period("wr_14", 16'h3FFF, 1'b0);

    // 6: starvation after 0x6000
    idle(2);
    send(16'h6000, r);
    run_period("st_0", 16'h003F, 1'b0);
    run_period("st_1", 16'h003F, 1'b1);
    run_period("st_2", 16'h003F, 1'b1);

    // 7: sample arriving on an empty-buffer wrap still flags underrun and waits
    send(16'h3000, r);
    chk("empty_wrap_rdy", r, 1'b1);
    run_period("ew_ur", 16'h003F, 1'b1);
    run_period("ew_3", 16'h0007, 1'b0);

    // 8: reset with a pending sample discards it
    idle(2);
    send(16'hF000, r);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_in_reset("disc_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_period("post_rst", 16'h00FF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
